// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               FSM state encodings and the default operand width.
// Revision    : 1.0  initial release
// ============================================================================
package seq_multiplier_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : seq_multiplier_pkg
`default_nettype wire

// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_if
// Description : Start/done handshake and operand/result bus between the
//               controlling FSM (master) and the multiplier (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface seq_multiplier_if
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Result;

    modport master (
        output start, A, B,
        input  busy, done, Result
    );

    modport slave (
        input  start, A, B,
        output busy, done, Result
    );
endinterface : seq_multiplier_if
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Multi-cycle unsigned shift-add multiplier, one multiplier bit
//               per clock, Result = A * B (2*WIDTH bits).
//               Optional macro EARLY_TERM_EN: leave RUN as soon as no set
//               multiplier bits remain.
// Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seq_multiplier_if.slave  bus
);

    localparam int              CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   c_LAST  = CW'(WIDTH - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_count;
    logic [2*WIDTH-1:0]     r_result;
    logic [2*WIDTH-1:0]     w_sum;
    logic                   w_accept;
    logic                   w_last;

    // A new request is taken in IDLE or DONE, never while a run is in flight.
    assign w_accept = bus.start && (r_state != S_RUN);

    // Accumulator value after this step's conditional add; the product fits
    // in 2*WIDTH bits so no carry-out is kept.
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef EARLY_TERM_EN
    // Stop once the remaining multiplier bits after this step are all zero.
    assign w_last = (r_count == c_LAST) || ((r_mplier >> 1) == '0);
`else
    assign w_last = (r_count == c_LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift-add one bit per cycle;
    // Result is only updated on the final step so it holds across a restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.A};
            r_mplier <= bus.B;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                r_result <= w_sum;
            end
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.Result = r_result;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Directed self-checking bench for seq_multiplier. Follows the
//               EARLY_TERM_EN macro for latency expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_multiplier_if #(.WIDTH(32)) bus ();

    seq_multiplier #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Cycle in which done is expected, counting the start cycle as 0.
    function automatic int exp_done(input logic [31:0] b);
`ifdef EARLY_TERM_EN
        int msb;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return msb + 2;
`else
        return 33;
`endif
    endfunction

    // Issue one operation and wait (bounded) for done; checks latency and product.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
        int cyc;
        bit seen;
        bus.A = a; bus.B = b; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (bus.done) seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done(b)));
        chk({tag, "_result"}, bus.Result, exp);
        step();
    endtask

    initial begin
        int lat;
        int inj;
        bit dn_seen;
        n_checks = 0;
        n_errors = 0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;

        // Reset state.
        rst = 1'b1;
        step();
        step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.Result, 64'd0);
        rst = 1'b0;
        step();

        // 7*6 with per-cycle busy/done profile.
        lat = exp_done(32'd6);
        bus.A = 32'd7; bus.B = 32'd6; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.A = 32'd99; bus.B = 32'd99;   // operands must already be latched
        for (int c = 1; c <= lat; c++) begin
            chk($sformatf("p7x6_busy_c%0d", c), 64'(bus.busy), 64'(c < lat));
            chk($sformatf("p7x6_done_c%0d", c), 64'(bus.done), 64'(c == lat));
            if (c < lat) step();
        end
        chk("p7x6_result", bus.Result, 64'd42);
        step();
        chk("p7x6_done_drops", 64'(bus.done), 64'd0);
        chk("p7x6_result_held", bus.Result, 64'd42);

        // Assorted products.
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max_x_max");
        do_op(32'd0,        32'd123,      64'd0,                "zero_x_123");
        do_op(32'd5,        32'd3,        64'd15,               "p5x3");
        do_op(32'd77,       32'd0,        64'd0,                "p77x0");
        do_op(32'h12345678, 32'h10,       64'h123456780,        "shift16");
        do_op(32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF, "max_x_1");
        do_op(32'd1,        32'h80000000, 64'h0000000080000000, "msb_only");

        // Start while running is ignored; start in DONE cycle is accepted.
        lat = exp_done(32'd3);
        inj = (lat > 6) ? 5 : lat - 1;
        bus.A = 32'd3; bus.B = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        dn_seen = 1'b0;
        for (int c = 1; c < lat; c++) begin
            if (bus.done) dn_seen = 1'b1;
            if (c == inj) begin
                bus.A = 32'd100; bus.B = 32'd100; bus.start = 1'b1;
            end
            step();
            bus.start = 1'b0;
        end
        chk("ign_no_early_done", 64'(dn_seen), 64'd0);
        chk("ign_done", 64'(bus.done), 64'd1);
        chk("ign_result", bus.Result, 64'd9);
        // Now in the DONE cycle: request a new operation.
        lat = exp_done(32'd5);
        bus.A = 32'd2; bus.B = 32'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            chk($sformatf("redo_done_c%0d", c), 64'(bus.done), 64'(c == lat));
            chk($sformatf("redo_result_c%0d", c), bus.Result, (c == lat) ? 64'd10 : 64'd9);
            if (c < lat) step();
        end
        step();

        // Reset in cycle 10 of a long run aborts with no done pulse.
        bus.A = 32'd7; bus.B = 32'h80000001; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_result", bus.Result, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        dn_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done || bus.busy) dn_seen = 1'b1;
            step();
        end
        chk("abort_stays_idle", 64'(dn_seen), 64'd0);

        // Reset and start together: reset wins.
        bus.A = 32'd4; bus.B = 32'd4; bus.start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_wins_busy", 64'(bus.busy), 64'd0);
        step();
        chk("rst_wins_idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_multiplier
`default_nettype wire
